// File: rtl/peripheral_registers_pkg.sv
// rtl/peripheral_registers_pkg.sv - register map, STATUS bit positions and serializer states
package peripheral_registers_pkg;

  localparam logic [6:0] REG_LEDS     = 7'd0;
  localparam logic [6:0] REG_TXDATA   = 7'd1;
  localparam logic [6:0] REG_STATUS   = 7'd2;
  localparam logic [6:0] REG_RXDATA   = 7'd3;
  localparam logic [6:0] REG_TIMER_LO = 7'd4;
  localparam logic [6:0] REG_TIMER_HI = 7'd5;

  localparam int STATUS_TX_FULL  = 0;
  localparam int STATUS_TX_EMPTY = 1;
  localparam int STATUS_RX_VALID = 2;
  localparam int STATUS_TX_BUSY  = 3;
  localparam int STATUS_OVERRUN  = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [15:0] pack_status(input logic overrun, input logic tx_busy,
                                              input logic rx_valid, input logic tx_empty,
                                              input logic tx_full);
    logic [15:0] s;
    s = '0;
    s[STATUS_OVERRUN]  = overrun;
    s[STATUS_TX_BUSY]  = tx_busy;
    s[STATUS_RX_VALID] = rx_valid;
    s[STATUS_TX_EMPTY] = tx_empty;
    s[STATUS_TX_FULL]  = tx_full;
    return s;
  endfunction

endpackage

// File: rtl/peripheral_registers_if.sv
// rtl/peripheral_registers_if.sv - hardware-register bus between core (master) and peripherals (slave)
interface peripheral_registers_if;

  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;

  modport master (
    output register_index,
    output register_read,
    output register_write,
    output register_write_value,
    input  register_read_value
  );

  modport slave (
    input  register_index,
    input  register_read,
    input  register_write,
    input  register_write_value,
    output register_read_value
  );

endinterface

// File: rtl/peripheral_registers_uart_transmitter.sv
// rtl/peripheral_registers_uart_transmitter.sv - 8N1 serializer popping bytes through a ready/valid handshake
module uart_transmitter #(
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       uart_tx
);
  import peripheral_registers_pkg::*;

  localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

  tx_state_t         state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              bit_done;

  assign bit_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= TX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // The final STOP cycle may accept the next byte, so frames run back to back.
  always_comb begin
    state_next = state;
    baud_next  = '0;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    tx_ready   = 1'b0;
    if (state != TX_IDLE) begin
      baud_next = bit_done ? '0 : baud_cnt + 1'b1;
    end
    case (state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          shift_next = tx_data;
          state_next = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) begin
          state_next = TX_DATA;
          bit_next   = '0;
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = TX_STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          tx_ready = 1'b1;
          if (tx_valid) begin
            shift_next = tx_data;
            state_next = TX_START;
          end else begin
            state_next = TX_IDLE;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign tx_busy = (state != TX_IDLE);
  assign uart_tx = (state == TX_START) ? 1'b0 :
                   (state == TX_DATA)  ? shift_reg[0] : 1'b1;

endmodule

// File: rtl/peripheral_registers.sv
// rtl/peripheral_registers.sv - register decode for LEDs, UART TX FIFO/serializer, UART RX holding and cycle timer
module peripheral_registers #(
  parameter int          CLOCKS_PER_BIT = 16,
  parameter int          TX_FIFO_DEPTH  = 4,
  parameter logic [31:0] TIMER_INIT     = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  peripheral_registers_if.slave        bus,
  output logic [15:0]                  leds,
  output logic                         uart_tx,
  input  logic                         rx_strobe,
  input  logic [7:0]                   rx_byte
);
  import peripheral_registers_pkg::*;

  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam logic [PW:0] FIFO_FULL_COUNT = (PW+1)'(TX_FIFO_DEPTH);

  logic        wr_en, rd_en;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_ready, tx_busy;
  logic        rxdata_rd, status_rd, timer_lo_rd;
  logic        rx_valid, overrun;
  logic [7:0]  rx_data;
  logic [31:0] timer;
  logic [15:0] timer_shadow;
  logic [15:0] read_mux;

  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_count;

  // A write strobe suppresses any read side effects in the same cycle.
  assign wr_en       = bus.register_write;
  assign rd_en       = bus.register_read && !bus.register_write;
  assign rxdata_rd   = rd_en && (bus.register_index == REG_RXDATA);
  assign status_rd   = rd_en && (bus.register_index == REG_STATUS);
  assign timer_lo_rd = rd_en && (bus.register_index == REG_TIMER_LO);

  assign tx_full  = (fifo_count == FIFO_FULL_COUNT);
  assign tx_empty = (fifo_count == '0);
  assign tx_push  = wr_en && (bus.register_index == REG_TXDATA) && !tx_full;
  assign tx_pop   = tx_ready && !tx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr] <= bus.register_write_value[7:0];
  end

  uart_transmitter #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(!tx_empty),
    .tx_data (fifo_mem[rd_ptr]),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .uart_tx (uart_tx)
  );

  // A new byte arriving during an RXDATA read replaces the byte being read, not an unread one.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      rx_data  <= '0;
    end else begin
      if (rx_strobe) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rxdata_rd) begin
        rx_valid <= 1'b0;
      end
      if (rx_strobe && rx_valid && !rxdata_rd) begin
        overrun <= 1'b1;
      end else if (status_rd) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer        <= TIMER_INIT;
      timer_shadow <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (timer_lo_rd) timer_shadow <= timer[31:16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds <= '0;
    end else if (wr_en && (bus.register_index == REG_LEDS)) begin
      leds <= bus.register_write_value;
    end
  end

  always_comb begin
    read_mux = '0;
    case (bus.register_index)
      REG_LEDS:     read_mux = leds;
      REG_STATUS:   read_mux = pack_status(overrun, tx_busy, rx_valid, tx_empty, tx_full);
      REG_RXDATA:   read_mux = {8'h00, rx_data};
      REG_TIMER_LO: read_mux = timer[15:0];
      REG_TIMER_HI: read_mux = timer_shadow;
      default:      read_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.register_read_value <= '0;
    end else if (bus.register_read && bus.register_write) begin
      bus.register_read_value <= '0;
    end else if (rd_en) begin
      bus.register_read_value <= read_mux;
    end
  end

endmodule

// File: tb/tb_peripheral_registers.sv
// tb/tb_peripheral_registers.sv - directed vectors and UART/RX/timer sequences for peripheral_registers
module tb_peripheral_registers;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aux_reset = 1'b1;
  logic [15:0] leds, leds1, leds2;
  logic        uart_tx, tx1, tx2;
  logic        rx_strobe = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        aux_strobe = 1'b0;
  logic [7:0]  aux_byte = 8'h00;
  int          checks = 0;
  int          errors = 0;

  peripheral_registers_if bus ();
  peripheral_registers_if bus1 ();
  peripheral_registers_if bus2 ();

  always #5 clk = ~clk;

  peripheral_registers dut (
    .clk(clk), .reset(reset), .bus(bus), .leds(leds), .uart_tx(uart_tx),
    .rx_strobe(rx_strobe), .rx_byte(rx_byte)
  );

  peripheral_registers #(.TIMER_INIT(32'h0000_FFF0)) dut_t1 (
    .clk(clk), .reset(aux_reset), .bus(bus1), .leds(leds1), .uart_tx(tx1),
    .rx_strobe(aux_strobe), .rx_byte(aux_byte)
  );

  peripheral_registers #(.TIMER_INIT(32'hFFFF_FFF0)) dut_t2 (
    .clk(clk), .reset(aux_reset), .bus(bus2), .leds(leds2), .uart_tx(tx2),
    .rx_strobe(aux_strobe), .rx_byte(aux_byte)
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [6:0]  idx;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [6:0] idx, input logic [15:0] val);
    bus.register_index = idx;
    bus.register_write_value = val;
    bus.register_write = 1'b1;
    step();
    bus.register_write = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] idx, output logic [15:0] val);
    bus.register_index = idx;
    bus.register_read = 1'b1;
    step();
    bus.register_read = 1'b0;
    val = bus.register_read_value;
  endtask

  task automatic read_check(input string name, input logic [6:0] idx, input logic [15:0] exp);
    logic [15:0] v;
    bus_read(idx, v);
    check(name, 32'(v), 32'(exp));
  endtask

  task automatic aux_read(input logic [6:0] idx, output logic [15:0] v1, output logic [15:0] v2);
    bus1.register_index = idx;
    bus2.register_index = idx;
    bus1.register_read = 1'b1;
    bus2.register_read = 1'b1;
    step();
    bus1.register_read = 1'b0;
    bus2.register_read = 1'b0;
    v1 = bus1.register_read_value;
    v2 = bus2.register_read_value;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_byte = b;
    rx_strobe = 1'b1;
    step();
    rx_strobe = 1'b0;
  endtask

  // Every cycle of each 16-cycle bit is compared, so bit length and frame spacing are exact.
  task automatic check_frame(input logic [7:0] b, input bit search);
    logic [9:0] bits;
    bit found;
    bit bad;
    bits = {1'b1, b, 1'b0};
    found = !search;
    bad = 1'b0;
    if (search) begin
      for (int i = 0; i < 64 && !found; i++) begin
        step();
        if (uart_tx === 1'b0) found = 1'b1;
      end
      check($sformatf("frame_%02h_start_seen", b), 32'(found), 32'd1);
      if (!found) return;
    end
    for (int k = 0; k < 160; k++) begin
      if (k > 0 || !search) step();
      if (k % 16 == 0) bad = 1'b0;
      if (uart_tx !== bits[k/16]) bad = 1'b1;
      if (k % 16 == 15) check($sformatf("frame_%02h_bit%0d_bad", b, k/16), 32'(bad), 32'd0);
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (uart_tx !== 1'b1) bad = 1'b1;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v1, v2;

    bus.register_index = '0; bus.register_read = 1'b0; bus.register_write = 1'b0;
    bus.register_write_value = '0;
    bus1.register_index = '0; bus1.register_read = 1'b0; bus1.register_write = 1'b0;
    bus1.register_write_value = '0;
    bus2.register_index = '0; bus2.register_read = 1'b0; bus2.register_write = 1'b0;
    bus2.register_write_value = '0;

    vecs[0]  = '{1'b1, 1'b0, 7'd0,   16'hA5A5, 16'h0000, 16'hA5A5};
    vecs[1]  = '{1'b0, 1'b1, 7'd0,   16'h0000, 16'hA5A5, 16'hA5A5};
    vecs[2]  = '{1'b0, 1'b1, 7'd9,   16'h0000, 16'h0000, 16'hA5A5};
    vecs[3]  = '{1'b1, 1'b0, 7'd9,   16'h1234, 16'h0000, 16'hA5A5};
    vecs[4]  = '{1'b0, 1'b1, 7'd0,   16'h0000, 16'hA5A5, 16'hA5A5};
    vecs[5]  = '{1'b1, 1'b0, 7'd0,   16'h5A5A, 16'hA5A5, 16'h5A5A};
    vecs[6]  = '{1'b0, 1'b1, 7'd1,   16'h0000, 16'h0000, 16'h5A5A};
    vecs[7]  = '{1'b0, 1'b1, 7'd2,   16'h0000, 16'h0002, 16'h5A5A};
    vecs[8]  = '{1'b0, 1'b1, 7'd3,   16'h0000, 16'h0000, 16'h5A5A};
    vecs[9]  = '{1'b0, 1'b1, 7'd127, 16'h0000, 16'h0000, 16'h5A5A};
    vecs[10] = '{1'b0, 1'b1, 7'd0,   16'h0000, 16'h5A5A, 16'h5A5A};
    vecs[11] = '{1'b1, 1'b1, 7'd0,   16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[12] = '{1'b0, 1'b1, 7'd5,   16'h0000, 16'h0000, 16'hFFFF};
    vecs[13] = '{1'b1, 1'b0, 7'd2,   16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[14] = '{1'b0, 1'b1, 7'd0,   16'h0000, 16'hFFFF, 16'hFFFF};

    repeat (3) @(posedge clk);
    #1;
    check("reset_read_value", 32'(bus.register_read_value), 32'h0);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_uart_tx", 32'(uart_tx), 32'h1);
    reset = 1'b0;
    read_check("reset_timer_lo", 7'd4, 16'h0000);
    read_check("reset_status", 7'd2, 16'h0002);
    read_check("reset_timer_hi", 7'd5, 16'h0000);

    for (int i = 0; i < 15; i++) begin
      bus.register_write = vecs[i].wr;
      bus.register_read = vecs[i].rd;
      bus.register_index = vecs[i].idx;
      bus.register_write_value = vecs[i].wdata;
      step();
      bus.register_write = 1'b0;
      bus.register_read = 1'b0;
      check($sformatf("vec%0d_read_value", i), 32'(bus.register_read_value), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
    end

    // Single byte 0x55 with STATUS sampled during the frame.
    bus_write(7'd1, 16'h0155);
    fork
      check_frame(8'h55, 1'b1);
      begin
        step();
        read_check("tx1_status_early", 7'd2, 16'h000A);
        repeat (80) step();
        read_check("tx1_status_mid", 7'd2, 16'h000A);
      end
    join
    step();
    read_check("tx1_status_after", 7'd2, 16'h0002);

    // Burst: 0x41 is popped at once, 0x42..0x45 fill the FIFO, 0x46 is dropped.
    fork
      begin
        check_frame(8'h41, 1'b1);
        for (int b = 8'h42; b <= 8'h45; b++) check_frame(8'(b), 1'b0);
      end
      begin
        for (int b = 8'h41; b <= 8'h46; b++) bus_write(7'd1, 16'(b));
        read_check("burst_status_full", 7'd2, 16'h0009);
      end
    join
    check_idle("burst_line_idle_after", 40);
    read_check("burst_status_after", 7'd2, 16'h0002);

    rx_pulse(8'h3C);
    rx_pulse(8'h7E);
    read_check("rx_status_overrun", 7'd2, 16'h0016);
    read_check("rx_data_latest", 7'd3, 16'h007E);
    read_check("rx_status_cleared", 7'd2, 16'h0002);

    rx_pulse(8'h11);
    rx_byte = 8'h22; rx_strobe = 1'b1;
    bus_read(7'd3, v1);
    rx_strobe = 1'b0;
    check("rx_coinc_rxdata_old", 32'(v1), 32'h0011);
    read_check("rx_coinc_rxdata_status", 7'd2, 16'h0006);
    read_check("rx_coinc_rxdata_new", 7'd3, 16'h0022);
    read_check("rx_coinc_rxdata_status2", 7'd2, 16'h0002);

    rx_pulse(8'h33);
    rx_byte = 8'h44; rx_strobe = 1'b1;
    bus_read(7'd2, v1);
    rx_strobe = 1'b0;
    check("rx_coinc_status_old", 32'(v1), 32'h0006);
    read_check("rx_coinc_status_set", 7'd2, 16'h0016);
    read_check("rx_coinc_status_clr", 7'd2, 16'h0006);
    read_check("rx_coinc_status_data", 7'd3, 16'h0044);

    // Timer: instance 1 crosses 0x0000FFFF, instance 2 wraps 0xFFFFFFFF -> 0.
    aux_reset = 1'b0;
    repeat (15) step();
    aux_read(7'd4, v1, v2);
    check("t1_lo_at_ffff", 32'(v1), 32'h0000FFFF);
    check("t2_lo_at_ffff", 32'(v2), 32'h0000FFFF);
    aux_read(7'd5, v1, v2);
    check("t1_hi_shadow", 32'(v1), 32'h0);
    check("t2_hi_shadow", 32'(v2), 32'h0000FFFF);
    aux_read(7'd4, v1, v2);
    check("t1_lo_after", 32'(v1), 32'h0001);
    check("t2_lo_after_wrap", 32'(v2), 32'h0001);
    aux_read(7'd5, v1, v2);
    check("t1_hi_after", 32'(v1), 32'h0001);
    check("t2_hi_after_wrap", 32'(v2), 32'h0000);

    // Reset in the middle of data bit 0 with two bytes still queued.
    read_check("pre_reset_leds_read", 7'd0, 16'hFFFF);
    bus_write(7'd1, 16'h0000);
    bus_write(7'd1, 16'h0000);
    bus_write(7'd1, 16'h0000);
    repeat (20) step();
    check("pre_reset_tx_data_bit", 32'(uart_tx), 32'h0);
    reset = 1'b1;
    step();
    check("midframe_reset_uart_tx", 32'(uart_tx), 32'h1);
    check("midframe_reset_leds", 32'(leds), 32'h0);
    check("midframe_reset_read_value", 32'(bus.register_read_value), 32'h0);
    reset = 1'b0;
    read_check("midframe_reset_timer_lo", 7'd4, 16'h0000);
    read_check("midframe_reset_status", 7'd2, 16'h0002);
    check_idle("midframe_reset_no_bits", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
